// File: rtl/na_pkg.sv
// Shared definitions for the number_analyzer sequencer: FSM encoding and
// result flag bit positions.
package na_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_GAP     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Bit positions inside res_flags = {timeout, pal, fib, odd}
    localparam int FLAG_ODD = 0;
    localparam int FLAG_FIB = 1;
    localparam int FLAG_PAL = 2;
    localparam int FLAG_TO  = 3;
    localparam int FLAG_W   = 4;

endpackage

// File: rtl/na_seq_table.sv
// Operand table: DEPTH x WIDTH register file, one write port, asynchronous
// read. Contents are deliberately not reset; writes to addresses at or
// beyond DEPTH are dropped.
module na_seq_table #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5,
    parameter int IDX_W = 3
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Table write; out-of-range addresses are ignored
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i < IDX_W'(DEPTH))) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read, zero for out-of-range indices
    always_comb begin
        rdata_o = '0;
        if (raddr_i < IDX_W'(DEPTH)) begin
            rdata_o = mem[raddr_i];
        end
    end

endmodule

// File: rtl/number_sequencer.sv
// Initiator for number_analyzer: walks the operand table, pulses the
// analyzer reset per entry, waits for its ready edge (or a timeout),
// streams per-entry results and keeps running odd/fib/pal totals.
//
// Handshake: na_reset is a one-cycle "request" that launches the analyzer on
// na_number; completion is the first rising edge of na_ready seen after the
// SETTLE cycle, and the na_odd/na_fib/na_pal flags are taken on that edge.
// Downstream res_valid is a one-cycle strobe with no back-pressure;
// res_index/res_flags are only meaningful while res_valid is high.
module number_sequencer
    import na_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 5,
    parameter int IDX_W   = 3,
    parameter int GAP     = 20,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              load_we,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [WIDTH-1:0]  load_data,
    input  logic [IDX_W-1:0]  count,
    input  logic              start,
    output logic [WIDTH-1:0]  na_number,
    output logic              na_reset,
    output logic              na_enable,
    input  logic              na_ready,
    input  logic              na_odd,
    input  logic              na_fib,
    input  logic              na_pal,
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_index,
    output logic [FLAG_W-1:0] res_flags,
    output logic [IDX_W-1:0]  odd_cnt,
    output logic [IDX_W-1:0]  fib_cnt,
    output logic [IDX_W-1:0]  pal_cnt,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);

    // One counter serves both the GAP wait and the WAIT timeout
    localparam int CNT_MAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [WIDTH-1:0] number_q, number_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pend_q, pend_d;
    logic [2:0]       flags_q, flags_d;
    logic             to_q, to_d;
    logic [IDX_W-1:0] odd_q, odd_d, fib_q, fib_d, pal_q, pal_d;
    logic             done_q, done_d;
    logic             ready_q;

    logic [WIDTH-1:0] rd_data;
    logic [IDX_W-1:0] n_start;
    logic             ready_rise;

    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign n_start    = (count > IDX_W'(DEPTH)) ? IDX_W'(DEPTH) : count;
    assign ready_rise = na_ready & ~ready_q;

    na_seq_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk_i   (clock),
        .we_i    (load_we & ~busy),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (idx_q),
        .rdata_o (rd_data)
    );

    // State and datapath registers; ready_q tracks na_ready every cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            n_q      <= '0;
            number_q <= '0;
            timer_q  <= '0;
            pend_q   <= 1'b0;
            flags_q  <= '0;
            to_q     <= 1'b0;
            odd_q    <= '0;
            fib_q    <= '0;
            pal_q    <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            number_q <= number_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            flags_q  <= flags_d;
            to_q     <= to_d;
            odd_q    <= odd_d;
            fib_q    <= fib_d;
            pal_q    <= pal_d;
            done_q   <= done_d;
            ready_q  <= na_ready;
        end
    end

    // Next-state logic; enable=0 holds everything except ready-edge capture
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        n_d      = n_q;
        number_d = number_q;
        timer_d  = timer_q;
        pend_d   = pend_q;
        flags_d  = flags_q;
        to_d     = to_q;
        odd_d    = odd_q;
        fib_d    = fib_q;
        pal_d    = pal_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE: begin
                if (enable && start) begin
                    n_d     = n_start;
                    idx_d   = '0;
                    odd_d   = '0;
                    fib_d   = '0;
                    pal_d   = '0;
                    done_d  = (n_start == '0);
                    state_d = (n_start == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (enable) begin
                    number_d = rd_data;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (enable) begin
                    timer_d = '0;
                    pend_d  = 1'b0;
                    to_d    = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An edge is latched even when frozen so it is not lost
                if (ready_rise && !pend_q) begin
                    flags_d = {na_pal, na_fib, na_odd};
                    pend_d  = ~enable;
                end
                if (enable) begin
                    if (ready_rise || pend_q) begin
                        pend_d  = 1'b0;
                        state_d = S_CAPTURE;
                    end else if (timer_q == CNT_W'(TIMEOUT - 1)) begin
                        to_d    = 1'b1;
                        flags_d = '0;
                        state_d = S_CAPTURE;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
            end
            S_CAPTURE: begin
                if (enable) begin
                    if (!to_q) begin
                        odd_d = odd_q + IDX_W'(flags_q[FLAG_ODD]);
                        fib_d = fib_q + IDX_W'(flags_q[FLAG_FIB]);
                        pal_d = pal_q + IDX_W'(flags_q[FLAG_PAL]);
                    end
                    if (idx_q == n_q - IDX_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        timer_d = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (enable) begin
                    if (timer_q == CNT_W'(GAP - 1)) begin
                        state_d = S_ISSUE;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are gated by enable so a frozen FSM never repeats them
    always_comb begin
        na_reset  = enable && (state_q == S_ISSUE);
        res_valid = enable && (state_q == S_CAPTURE);
        na_number = (state_q == S_ISSUE) ? rd_data : number_q;
    end

    assign na_enable = busy;
    assign res_index = idx_q;
    assign res_flags = {to_q, flags_q};
    assign odd_cnt   = odd_q;
    assign fib_cnt   = fib_q;
    assign pal_cnt   = pal_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_number_sequencer.sv
// Bench for number_sequencer with a behavioural number_analyzer stand-in
// (random latency, or never ready) and a queue-based result scoreboard.
module tb_number_sequencer;
    import na_pkg::*;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 5;
    localparam int IDX_W   = 3;
    localparam int GAP     = 20;
    localparam int TIMEOUT = 16;

    logic              clock, reset, enable, load_we, start;
    logic [IDX_W-1:0]  load_addr, count;
    logic [WIDTH-1:0]  load_data, na_number;
    logic              na_reset, na_enable, na_ready, na_odd, na_fib, na_pal;
    logic              res_valid, busy, done;
    logic [IDX_W-1:0]  res_index, odd_cnt, fib_cnt, pal_cnt;
    logic [3:0]        res_flags;
    state_t            dbg_state;

    number_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .count(count), .start(start),
        .na_number(na_number), .na_reset(na_reset), .na_enable(na_enable),
        .na_ready(na_ready), .na_odd(na_odd), .na_fib(na_fib), .na_pal(na_pal),
        .res_valid(res_valid), .res_index(res_index), .res_flags(res_flags),
        .odd_cnt(odd_cnt), .fib_cnt(fib_cnt), .pal_cnt(pal_cnt),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_bad = 0;
    int nres_cnt = 0;
    int res_seen = 0;
    bit stuck = 1'b0;
    logic [WIDTH-1:0] mdl_tbl [DEPTH];
    logic [IDX_W+3:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic bit ref_fib(input logic [WIDTH-1:0] v);
        longint a = 0, b = 1, t;
        while (a < longint'(v)) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a == longint'(v);
    endfunction

    function automatic bit ref_pal(input logic [WIDTH-1:0] v);
        longint x = longint'(v), r = 0;
        while (x > 0) begin
            r = r * 10 + x % 10;
            x = x / 10;
        end
        return r == longint'(v);
    endfunction

    function automatic logic [WIDTH-1:0] rand_val();
        longint a = 1, b = 2, t;
        case ($urandom_range(0, 2))
            0: begin
                repeat ($urandom_range(0, 40)) begin
                    t = a + b; a = b; b = t;
                end
                return WIDTH'(a);
            end
            1: return WIDTH'($urandom_range(1, 9) * 10001 + $urandom_range(0, 9) * 1010
                              + $urandom_range(0, 9) * 100);
            default: return WIDTH'($urandom_range(1, 32'h7fff_ffff));
        endcase
    endfunction

    // ---------------- analyzer stand-in ----------------
    int an_lat = 0;
    logic [WIDTH-1:0] an_num;
    always @(posedge clock) begin
        if (reset) begin
            na_ready <= 1'b0;
            an_lat   <= 0;
        end else if (na_reset) begin
            na_ready <= 1'b0;
            an_num   <= na_number;
            an_lat   <= $urandom_range(2, 12);
        end else if (na_enable && an_lat > 0) begin
            an_lat <= an_lat - 1;
            if (an_lat == 1 && !stuck) begin
                na_ready <= 1'b1;
                na_odd   <= an_num[0];
                na_fib   <= ref_fib(an_num);
                na_pal   <= ref_pal(an_num);
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [IDX_W+3:0] e;
        if (na_reset) nres_cnt++;
        if (res_valid) begin
            res_seen++;
            if (exp_q.size() == 0) begin
                chk("res_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("res_index", res_index, e[IDX_W+3:4]);
                chk("res_flags", res_flags, e[3:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_entry(input int addr, input logic [WIDTH-1:0] data);
        load_we = 1'b1; load_addr = IDX_W'(addr); load_data = data;
        tick();
        load_we = 1'b0;
        if (addr < DEPTH) mdl_tbl[addr] = data;
    endtask

    task automatic build_exp(input int cnt, output int eo, output int ef, output int ep);
        int n = (cnt > DEPTH) ? DEPTH : cnt;
        logic [3:0] f;
        eo = 0; ef = 0; ep = 0;
        for (int i = 0; i < n; i++) begin
            if (stuck) begin
                f = 4'b1000;
            end else begin
                f = {1'b0, ref_pal(mdl_tbl[i]), ref_fib(mdl_tbl[i]), mdl_tbl[i][0]};
                eo += int'(f[0]); ef += int'(f[1]); ep += int'(f[2]);
            end
            exp_q.push_back({IDX_W'(i), f});
        end
    endtask

    task automatic run(input int cnt, input bit freeze, input bit poke);
        int eo, ef, ep, k, nres0;
        int n = (cnt > DEPTH) ? DEPTH : cnt;
        bit froze = 1'b0;
        build_exp(cnt, eo, ef, ep);
        nres0 = nres_cnt;
        count = IDX_W'(cnt); start = 1'b1;
        tick();
        start = 1'b0;
        for (k = 0; k < 6000 && !done; k++) begin
            if (freeze && !froze && dbg_state == S_WAIT) begin
                enable = 1'b0;
                repeat (50) tick();
                enable = 1'b1;
                froze = 1'b1;
            end else if (poke && k == 40) begin
                start = 1'b1; count = 3'd1;
                load_we = 1'b1; load_addr = 3'd2; load_data = 32'd7;
                tick();
                start = 1'b0; load_we = 1'b0;
            end else begin
                tick();
            end
        end
        if (n == 0) chk("cnt0_done_quick", k <= 1, 1);
        chk("run_done", done, 1);
        chk("run_busy_low", busy, 0);
        chk("odd_total", odd_cnt, eo);
        chk("fib_total", fib_cnt, ef);
        chk("pal_total", pal_cnt, ep);
        chk("results_drained", exp_q.size(), 0);
        chk("na_reset_pulses", nres_cnt - nres0, n);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, base;
        logic [WIDTH-1:0] spec_vals [DEPTH];
        spec_vals = '{32'd1346269, 32'd1187811, 32'd832040, 32'd13469, 32'd1669};
        reset = 1'b1; enable = 1'b1; load_we = 1'b0; start = 1'b0;
        load_addr = '0; load_data = '0; count = '0;
        na_odd = 1'b0; na_fib = 1'b0; na_pal = 1'b0;
        tick(); tick();
        chk("rst_na_number", na_number, 0);
        chk("rst_na_reset", na_reset, 0);
        chk("rst_na_enable", na_enable, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_index", res_index, 0);
        chk("rst_res_flags", res_flags, 0);
        chk("rst_totals", {odd_cnt, fib_cnt, pal_cnt}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        reset = 1'b0;
        tick();

        // Directed table, full run
        for (int i = 0; i < DEPTH; i++) load_entry(i, spec_vals[i]);
        run(5, 1'b0, 1'b0);
        chk("dir_odd", odd_cnt, 4);
        chk("dir_fib", fib_cnt, 2);
        chk("dir_pal", pal_cnt, 1);

        // Zero-length run
        run(0, 1'b0, 1'b0);

        // Freeze mid-WAIT
        run(5, 1'b1, 1'b0);
        chk("frz_totals", {odd_cnt, fib_cnt, pal_cnt}, {3'd4, 3'd2, 3'd1});

        // start/load pulsed while busy, then rerun to confirm table intact
        run(5, 1'b0, 1'b1);
        run(5, 1'b0, 1'b0);

        // Reset during GAP after the second result
        begin
            int eo, ef, ep;
            build_exp(5, eo, ef, ep);
            base = res_seen;
            count = 3'd5; start = 1'b1;
            tick();
            start = 1'b0;
            for (k = 0; k < 3000; k++) begin
                if (res_seen - base >= 2 && dbg_state == S_GAP) break;
                tick();
            end
            chk("reached_gap2", k < 3000, 1);
            reset = 1'b1;
            tick();
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_totals", {odd_cnt, fib_cnt, pal_cnt}, 0);
            chk("mid_rst_done", done, 0);
            chk("mid_rst_na_reset", na_reset, 0);
            reset = 1'b0;
            exp_q.delete();
            tick();
            run(5, 1'b0, 1'b0);
        end

        // Analyzer that never answers
        stuck = 1'b1;
        run(3, 1'b0, 1'b0);
        stuck = 1'b0;

        // Randomized tables and counts
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < DEPTH; i++) load_entry(i, rand_val());
            load_entry($urandom_range(DEPTH, 7), rand_val());
            run($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
